// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
//   state_t     : controller states (IDLE, RUN)
//   num_digits  : digit steps per operation, WIDTH/DIGIT
//   cnt_width   : digit counter width, $clog2(N) but never below 1
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = width / digit;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_rca_slice.sv
// rca_slice: purely combinational DIGIT-bit ripple-carry adder.
//   x, y  : DIGIT-bit addends
//   ci    : carry in
//   s     : DIGIT-bit sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (used for two's-complement overflow)
module rca_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle a + b + cin, DIGIT bits per clock through one
// rca_slice with a registered carry between digits.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : request an addition (sampled only while idle)
//   a, b, cin        : operands, captured on the accepting edge
//   busy             : operation in progress
//   done             : one-cycle pulse when sum/cout/overflow update
//   sum, cout        : (a+b+cin) mod 2^WIDTH and carry out, held until next completion
//   overflow         : two's-complement overflow of the full-width add
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(WIDTH, DIGIT);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
      $fatal(1, "serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;

   logic [DIGIT-1:0] s;
   logic             co, c_msb;

   // {s, res_sr} >> DIGIT keeps the slice valid when DIGIT == WIDTH
   logic [WIDTH+DIGIT-1:0] res_cat;

   rca_slice #(.DIGIT(DIGIT)) u_slice (
      .x     (a_sr[DIGIT-1:0]),
      .y     (b_sr[DIGIT-1:0]),
      .ci    (carry),
      .s     (s),
      .co    (co),
      .c_msb (c_msb)
   );

   assign res_cat = {s, res_sr};
   assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];
   assign last    = (cnt == CW'(N - 1));
   assign busy    = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sr   <= a;
               b_sr   <= b;
               carry  <= cin;
               res_sr <= '0;
               cnt    <= '0;
            end
         end else begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            carry  <= co;
            res_sr <= res_nx;
            cnt    <= cnt + CW'(1);
            if (last) begin
               // only the final digit's carries describe the MSB
               sum      <= res_nx;
               cout     <= co;
               overflow <= co ^ c_msb;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases on a 16/4 instance,
// plus random sweeps over several WIDTH/DIGIT pairs against a plain
// arithmetic reference ({cout,sum} = a + b + cin).
module tb_serial_adder;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main 16/4 instance ----------------
   logic        rst_n, start, cin, busy, done, cout, overflow;
   logic [15:0] a, b, sum;

   serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
   );

   // reference model for the 16-bit instance
   task automatic ref16(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output logic [15:0] s, output logic co, output logic ov);
      logic [16:0] r;
      r  = {1'b0, x} + {1'b0, y} + {16'd0, c};
      s  = r[15:0];
      co = r[16];
      ov = (x[15] == y[15]) && (s[15] != x[15]);
   endtask

   // one operation; hold keeps start high while running (must be ignored)
   task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input bit hold);
      logic [15:0] es;
      logic        ec, eo;
      int          lat, busy_cyc;
      ref16(x, y, c, es, ec, eo);
      @(negedge clk);
      start = 1'b1; a = x; b = y; cin = c;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 0; busy_cyc = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"},  lat, 4);
      chk({tag, "_busy"}, busy_cyc, 4);
      chk({tag, "_bd"},   {31'd0, busy & done}, 0);
      chk({tag, "_sum"},  {16'd0, sum}, {16'd0, es});
      chk({tag, "_co"},   {31'd0, cout}, {31'd0, ec});
      chk({tag, "_ov"},   {31'd0, overflow}, {31'd0, eo});
   endtask

   // ---------------- parameter sweep instances ----------------
   localparam int NS = 5;
   localparam int SW[NS] = '{16, 16, 16, 16, 8};
   localparam int SD[NS] = '{1, 2, 4, 16, 8};
   logic          rst_s;
   bit [NS-1:0]   sw_fin = '0;

   for (genvar g = 0; g < NS; g++) begin : g_sw
      localparam int W  = SW[g];
      localparam int D  = SD[g];
      localparam int NN = W / D;
      logic         st, ci, bs, dn, co, ov;
      logic [W-1:0] x, y, s;

      serial_adder #(.WIDTH(W), .DIGIT(D)) u (
         .clk(clk), .rst_n(rst_s), .start(st), .a(x), .b(y), .cin(ci),
         .busy(bs), .done(dn), .sum(s), .cout(co), .overflow(ov)
      );

      initial begin
         logic [W:0]   r;
         logic [W-1:0] xa, yb;
         logic         c, eo;
         int           lat;
         st = 1'b0; x = '0; y = '0; ci = 1'b0;
         wait (rst_s === 1'b1);
         for (int i = 0; i < 1000; i++) begin
            xa = W'($urandom); yb = W'($urandom); c = i[0];
            if (i < 4) begin            // corner operands first
               xa = {W{1'b1}};
               yb = (i < 2) ? '0 : {W{1'b1}};
            end
            r  = {1'b0, xa} + {1'b0, yb} + {{W{1'b0}}, c};
            eo = (xa[W-1] == yb[W-1]) && (r[W-1] != xa[W-1]);
            @(negedge clk);
            st = 1'b1; x = xa; y = yb; ci = c;
            @(posedge clk); #1;
            st = 1'b0; x = W'($urandom); y = W'($urandom);
            lat = 0;
            while (!dn && lat < 40) begin
               @(posedge clk); #1;
               lat++;
            end
            chk($sformatf("sw%0d_lat", g), lat, NN);
            chk($sformatf("sw%0d_res", g), 32'({co, s}), 32'(r));
            chk($sformatf("sw%0d_ov", g), {31'd0, ov}, {31'd0, eo});
         end
         sw_fin[g] = 1'b1;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sawdone;
      rst_n = 1'b0; rst_s = 1'b0;
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_res",  {15'd0, cout, sum}, 0);
      chk("rst_ov",   {31'd0, overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1; rst_s = 1'b1;

      op16("basic", 16'h1234, 16'h4321, 1'b0, 0);
      chk("basic_k", {16'd0, sum}, 32'h5555);
      op16("chain1", 16'hFFFF, 16'h0000, 1'b1, 0);
      chk("chain1_k", {15'd0, cout, sum}, 32'h10000);
      op16("chain2", 16'h7FFF, 16'h0001, 1'b0, 0);
      chk("chain2_k", {15'd0, overflow, sum}, 32'h18000);

      // start pulse while busy must be ignored and not queued
      @(negedge clk);
      start = 1'b1; a = 16'h0100; b = 16'h0200; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sawdone = 0;
      for (int i = 0; i < 10 && !done; i++) @(posedge clk) #1;
      chk("ign_sum", {16'd0, sum}, 32'h0300);
      @(posedge clk); #1;
      chk("ign_noq", {31'd0, busy}, 0);

      // back-to-back with start held across done
      for (int i = 0; i < 6; i++)
         op16($sformatf("b2b%0d", i), i[0] ? 16'hA5A5 : 16'h1F0F,
              i[0] ? 16'h5A5B : 16'h00F1, i[1], 1);
      start = 1'b0;
      @(posedge clk); #1;
      chk("b2b_idle", {31'd0, busy}, 0);

      // reset two cycles after acceptance
      @(negedge clk);
      start = 1'b1; a = 16'h7777; b = 16'h1111; cin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_busy", {31'd0, busy}, 0);
      chk("mrst_res",  {14'd0, overflow, cout, sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) sawdone++;
      end
      chk("mrst_nodone", sawdone, 0);
      op16("post", 16'h0001, 16'h0001, 1'b0, 0);
      chk("post_k", {16'd0, sum}, 32'h0002);

      for (int i = 0; i < 200; i++)
         op16("rnd", 16'($urandom), 16'($urandom), 1'($urandom), 0);

      wait (&sw_fin);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
